// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared 7-segment code table (active-low, seg[6]=a ... seg[0]=g)
//            and the pattern -> {valid, nibble} lookup used by the decoder.
// Contents : SEG_0..SEG_F, SEG_BLANK, seg7_dec_t, seg7_to_hex()
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef struct packed {
      logic       valid;
      logic [3:0] nibble;
   } seg7_dec_t;

   // Unknown patterns return valid=0 with nibble 0.
   function automatic seg7_dec_t seg7_to_hex(input logic [6:0] seg);
      seg7_dec_t r;
      r.valid  = 1'b1;
      r.nibble = 4'h0;
      case (seg)
         SEG_0:   r.nibble = 4'h0;
         SEG_1:   r.nibble = 4'h1;
         SEG_2:   r.nibble = 4'h2;
         SEG_3:   r.nibble = 4'h3;
         SEG_4:   r.nibble = 4'h4;
         SEG_5:   r.nibble = 4'h5;
         SEG_6:   r.nibble = 4'h6;
         SEG_7:   r.nibble = 4'h7;
         SEG_8:   r.nibble = 4'h8;
         SEG_9:   r.nibble = 4'h9;
         SEG_A:   r.nibble = 4'hA;
         SEG_B:   r.nibble = 4'hB;
         SEG_C:   r.nibble = 4'hC;
         SEG_D:   r.nibble = 4'hD;
         SEG_E:   r.nibble = 4'hE;
         SEG_F:   r.nibble = 4'hF;
         default: r.valid  = 1'b0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_decode
// Purpose  : Combinational lookup of one active-low segment pattern.
// Ports    : i_seg[6:0]    segment pattern (seg[6]=a ... seg[0]=g)
//            o_nibble[3:0] decoded hex digit (0 when invalid)
//            o_valid       pattern is a legal code
// Config   : SEG7_BLANK_EN - all-segments-off decodes as a valid 0
// Revision : 1.0  initial release
// ============================================================================
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_nibble,
   output logic       o_valid
);

   seg7_dec_t w_dec;

   always_comb begin
      w_dec    = seg7_to_hex(i_seg);
      o_nibble = w_dec.nibble;
      o_valid  = w_dec.valid;
`ifdef SEG7_BLANK_EN
      // A dark digit (e.g. leading-zero suppression) is legal, not an error.
      if (i_seg == SEG_BLANK) begin
         o_nibble = 4'h0;
         o_valid  = 1'b1;
      end
`endif
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Purpose  : Snoops a multiplexed common-anode 7-seg bus and rebuilds the
//            displayed hex value, one digit per stable anode dwell.
// Ports    : clk, rst (sync, active-high)
//            seg[6:0]          segment pins, active low (async)
//            an[DIGITS-1:0]    anode pins, active low (async)
//            hex_out           last complete frame, digit i at [4i+3:4i]
//            err_out           per-digit invalid-pattern flags
//            frame_vld         1-cycle pulse on hex_out/err_out update
//            stale             no capture for TIMEOUT cycles
// Config   : SEG7_BLANK_EN (passed to seg7_pattern_decode)
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 65535
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   hex_out,
   output logic [DIGITS-1:0]     err_out,
   output logic                  frame_vld,
   output logic                  stale
);

   localparam int WW = DIGITS + 7;
   localparam int CW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [DIGITS-1:0] c_one = {{(DIGITS-1){1'b0}}, 1'b1};

   logic [WW-1:0]       r_sync1, r_sync2;
   logic [CW-1:0]       r_stable_cnt;
   logic [DIGITS-1:0]   r_mask, r_pend_err;
   logic [4*DIGITS-1:0] r_pend_hex;
   logic [TW-1:0]       r_to_cnt;

   logic [DIGITS-1:0]   w_an_act;
   logic                w_changed, w_onehot, w_capture, w_done;
   logic [3:0]          w_nibble;
   logic                w_valid;

   assign w_an_act  = ~r_sync2[WW-1:7];
   // r_sync1 holds the value r_sync2 will take next edge, so a difference
   // means the synchronized word changes this edge.
   assign w_changed = (r_sync1 != r_sync2);
   assign w_onehot  = (w_an_act != '0) && ((w_an_act & (w_an_act - c_one)) == '0);
   // Fires only on the SETTLE-1 -> SETTLE step, so once per dwell.
   assign w_capture = !w_changed && (r_stable_cnt == CW'(SETTLE - 1)) && w_onehot;
   assign w_done    = &r_mask;

   seg7_pattern_decode u_decode (
      .i_seg    (r_sync2[6:0]),
      .o_nibble (w_nibble),
      .o_valid  (w_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_stable_cnt <= '0;
      end else begin
         r_sync1 <= {an, seg};
         r_sync2 <= r_sync1;
         if (w_changed)
            r_stable_cnt <= '0;
         else if (r_stable_cnt != CW'(SETTLE))
            r_stable_cnt <= r_stable_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mask     <= '0;
         r_pend_err <= '0;
         r_pend_hex <= '0;
         hex_out    <= '0;
         err_out    <= '0;
         frame_vld  <= 1'b0;
      end else begin
         frame_vld <= w_done;
         if (w_done) begin
            hex_out <= r_pend_hex;
            err_out <= r_pend_err;
         end
         for (int i = 0; i < DIGITS; i++) begin
            if (w_capture && w_an_act[i]) begin
               r_mask[i]            <= 1'b1;
               r_pend_hex[4*i +: 4] <= w_nibble;
               r_pend_err[i]        <= !w_valid;
            end else if (w_done) begin
               r_mask[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_cnt <= '0;
         stale    <= 1'b0;
      end else begin
         if (w_capture)
            r_to_cnt <= '0;
         else if (r_to_cnt != TW'(TIMEOUT))
            r_to_cnt <= r_to_cnt + 1'b1;
         // Set in the same edge the counter lands on TIMEOUT; a capture
         // that edge keeps the counter (and stale) from advancing.
         if (w_done)
            stale <= 1'b0;
         else if (!w_capture && (r_to_cnt >= TW'(TIMEOUT - 1)))
            stale <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Purpose  : Self-checking bench for seg7_scan_decoder (DIGITS=4, SETTLE=4,
//            TIMEOUT=64). Directed scans plus randomized dwells checked
//            against a dwell-level reference model.
// Config   : SEG7_BLANK_EN selects the blank-digit expectation
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_decoder;

   localparam int DIGITS  = 4;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = 7'h7F;
   logic [3:0]  an  = 4'hF;
   logic [15:0] hex_out;
   logic [3:0]  err_out;
   logic        frame_vld;
   logic        stale;

   seg7_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg       (seg),
      .an        (an),
      .hex_out   (hex_out),
      .err_out   (err_out),
      .frame_vld (frame_vld),
      .stale     (stale)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- reference model (dwell level) ----------------
   logic [6:0]  m_tbl [16];
   logic [10:0] m_word;
   logic [15:0] m_hex;
   logic [3:0]  m_errv;
   logic [3:0]  m_mask;
   logic [19:0] exp_q [$];

   function automatic void m_decode(input logic [6:0] s, output logic [3:0] nib, output logic err);
      nib = 4'h0;
      err = 1'b1;
      for (int k = 0; k < 16; k++)
         if (m_tbl[k] == s) begin
            nib = 4'(k);
            err = 1'b0;
         end
`ifdef SEG7_BLANK_EN
      if (s == 7'h7F) err = 1'b0;
`endif
   endfunction

   // Present {a,s} for len cycles. A dwell is captured when the word changed,
   // the anodes select exactly one digit and the word survives SETTLE+1 cycles.
   task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
      logic [10:0] w;
      logic [3:0]  act, nib;
      logic        e;
      int          d;
      w   = {a, s};
      act = ~a;
      an  = a;
      seg = s;
      if (w != m_word && len >= SETTLE + 1 && $countones(act) == 1) begin
         d = 0;
         for (int k = 0; k < 4; k++) if (act[k]) d = k;
         m_decode(s, nib, e);
         m_hex[4*d +: 4] = nib;
         m_errv[d]       = e;
         m_mask[d]       = 1'b1;
         if (m_mask == 4'hF) begin
            exp_q.push_back({m_errv, m_hex});
            m_mask = 4'h0;
         end
      end
      m_word = w;
      repeat (len) @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
      dwell(4'b1110, s0, 10);
      dwell(4'b1101, s1, 10);
      dwell(4'b1011, s2, 10);
      dwell(4'b0111, s3, 10);
   endtask

   task automatic do_reset();
      dwell(4'hF, 7'h7F, 10);
      chk("frames_pending_at_reset", exp_q.size(), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      m_word = 11'h7FF;
      m_mask = 4'h0;
      m_hex  = 16'h0;
      m_errv = 4'h0;
   endtask

   // ---------------- frame monitor ----------------
   int cyc    = 0;
   int fv_cyc = 0;
   int n_fv   = 0;

   always @(posedge clk) begin
      logic [19:0] e;
      cyc++;
      #1;
      if (frame_vld) begin
         n_fv++;
         fv_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_frame_vld", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("frame_hex", 32'(hex_out), 32'(e[15:0]));
            chk("frame_err", 32'(err_out), 32'(e[19:16]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t0, n0, len;
      logic [3:0] a;
      logic [6:0] s;

      m_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      m_word = 11'h7FF; m_mask = 4'h0; m_hex = 16'h0; m_errv = 4'h0;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      do_reset();
      chk("rst_hex", 32'(hex_out), 0);
      chk("rst_err", 32'(err_out), 0);
      chk("rst_fv", 32'(frame_vld), 0);
      chk("rst_stale", 32'(stale), 0);

      // 1: two full scans of F,3,A,1; measure latency on the second
      scan(m_tbl[15], m_tbl[3], m_tbl[10], m_tbl[1]);
      dwell(4'b1110, m_tbl[15], 10);
      dwell(4'b1101, m_tbl[3], 10);
      dwell(4'b1011, m_tbl[10], 10);
      t0 = cyc;
      dwell(4'b0111, m_tbl[1], 10);
      chk("t1_latency", 32'(fv_cyc - t0), 32'(SETTLE + 3));
      chk("t1_hex", 32'(hex_out), 32'h1A3F);
      chk("t1_err", 32'(err_out), 0);
      chk("t1_frames", 32'(n_fv), 2);

      // 2: 2-cycle all-on glitch inside the digit-1 dwell
      n0 = n_fv;
      dwell(4'b1110, m_tbl[15], 10);
      dwell(4'b1101, m_tbl[3], 6);
      dwell(4'b1101, 7'b0000000, 2);
      dwell(4'b1101, m_tbl[3], 6);
      dwell(4'b1011, m_tbl[10], 10);
      dwell(4'b0111, m_tbl[1], 10);
      chk("t2_hex", 32'(hex_out), 32'h1A3F);
      chk("t2_frames", 32'(n_fv - n0), 1);

      // 3: invalid pattern on digit 2
      scan(m_tbl[15], m_tbl[3], 7'b1111110, m_tbl[1]);
      chk("t3_hex", 32'(hex_out), 32'h103F);
      chk("t3_err", 32'(err_out), 32'h4);

      // 4: two anodes active, then idle -> stale; full scan clears it
      dwell(4'b1100, m_tbl[3], 20);
      chk("t4_not_stale_yet", 32'(stale), 0);
      dwell(4'hF, 7'h7F, 64);
      chk("t4_stale", 32'(stale), 1);
      chk("t4_hex_held", 32'(hex_out), 32'h103F);
      dwell(4'b1110, m_tbl[15], 10);
      dwell(4'b1101, m_tbl[3], 10);
      dwell(4'b1011, m_tbl[10], 10);
      chk("t4_stale_until_frame", 32'(stale), 1);
      dwell(4'b0111, m_tbl[1], 10);
      chk("t4_stale_cleared", 32'(stale), 0);
      chk("t4_hex", 32'(hex_out), 32'h1A3F);

      // 5: reset after two digits discards the partial frame
      dwell(4'b1110, m_tbl[5], 10);
      dwell(4'b1101, m_tbl[6], 10);
      do_reset();
      chk("t5_rst_hex", 32'(hex_out), 0);
      chk("t5_rst_err", 32'(err_out), 0);
      n0 = n_fv;
      dwell(4'b1011, m_tbl[7], 10);
      dwell(4'b0111, m_tbl[8], 10);
      dwell(4'hF, 7'h7F, 10);
      chk("t5_no_frame", 32'(n_fv - n0), 0);
      dwell(4'b1110, m_tbl[5], 10);
      dwell(4'b1101, m_tbl[6], 10);
      chk("t5_frame", 32'(n_fv - n0), 1);
      chk("t5_hex", 32'(hex_out), 32'h8765);

      // 6: blank digit 3
      scan(m_tbl[15], m_tbl[3], m_tbl[10], 7'h7F);
      chk("t6_hex", 32'(hex_out), 32'h0A3F);
`ifdef SEG7_BLANK_EN
      chk("t6_err", 32'(err_out), 0);
`else
      chk("t6_err", 32'(err_out), 32'h8);
`endif

      // Randomized dwells, including sub-SETTLE glitches and bad anodes
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) != 0) a = ~(4'b0001 << $urandom_range(0, 3));
         else                           a = 4'($urandom);
         if ($urandom_range(0, 3) != 0) s = m_tbl[$urandom_range(0, 15)];
         else                           s = 7'($urandom);
         if ($urandom_range(0, 4) == 0) len = $urandom_range(1, SETTLE);
         else                           len = $urandom_range(SETTLE + 1, SETTLE + 8);
         dwell(a, s, len);
      end
      dwell(4'hF, 7'h7F, 12);
      chk("rand_frames_left", exp_q.size(), 0);
      chk("rand_stale", 32'(stale), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
